// File: rtl/timing_gen_pkg.sv
// timing_gen_pkg: shared codes for the 4004 machine-cycle sequencer.
//   ST_*      : 3-bit state codes, A1=0 ... X3=7, in sequencing order.
//   SP_*      : 2-bit subphase codes within a state.
//   strobes_t : one bit per state strobe; bit position equals the state code.
package timing_gen_pkg;

    localparam logic [2:0] ST_A1 = 3'd0;
    localparam logic [2:0] ST_A2 = 3'd1;
    localparam logic [2:0] ST_A3 = 3'd2;
    localparam logic [2:0] ST_M1 = 3'd3;
    localparam logic [2:0] ST_M2 = 3'd4;
    localparam logic [2:0] ST_X1 = 3'd5;
    localparam logic [2:0] ST_X2 = 3'd6;
    localparam logic [2:0] ST_X3 = 3'd7;

    localparam logic [1:0] SP_C1 = 2'd0;   // clk1 subphase
    localparam logic [1:0] SP_G1 = 2'd1;   // gap after clk1
    localparam logic [1:0] SP_C2 = 2'd2;   // clk2 subphase
    localparam logic [1:0] SP_G2 = 2'd3;   // gap after clk2, last of the state

    // Field order puts a12 at bit 0 so a plain shift by the state code
    // produces the matching one-hot strobe set.
    typedef struct packed {
        logic x32;
        logic x22;
        logic x12;
        logic m22;
        logic m12;
        logic a32;
        logic a22;
        logic a12;
    } strobes_t;

    function automatic strobes_t state_strobes(input logic [2:0] st);
        return strobes_t'(8'd1 << st);
    endfunction

endpackage

// File: rtl/timing_gen_phase_div.sv
// phase_div: sysclk divider and subphase counter.
//   sysclk : clock, rising edge
//   poc_n  : synchronous active-low reset
//   clr    : synchronous clear, holds both counters at 0
//   sub    : current subphase (SP_C1..SP_G2)
//   tc     : high on the last sysclk of the last subphase of a state
module phase_div
    import timing_gen_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       sysclk,
    input  logic       poc_n,
    input  logic       clr,
    output logic [1:0] sub,
    output logic       tc
);

    // Keep at least one bit so CLK_DIV==1 still elaborates; div then stays 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             div_last;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));
    assign tc       = div_last && (sub == SP_G2);

    always_ff @(posedge sysclk) begin
        if (!poc_n || clr) begin
            div <= '0;
            sub <= SP_C1;
        end else if (div_last) begin
            div <= '0;
            sub <= sub + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/timing_gen.sv
// timing_gen: machine-cycle sequencer for the 4004 core boards.
//   sysclk      : clock, rising edge
//   poc_n       : synchronous active-low reset
//   run         : 1 free-run, 0 halt at the next machine-cycle boundary
//   clk1, clk2  : two-phase subphase clocks (subphase 0 / subphase 2)
//   a12..x32    : state strobes, one per state A1..X3
//   x21_clk2    : active-low, clk2 of X2
//   x31_clk2    : active-low, clk2 of X3
//   sync_n      : active-low, whole of X3
//   poc         : power-on clear to the other boards
//   halted      : parked in HALT
//   mcycle_cnt  : completed machine cycles, wrapping
// All outputs are registered decodes of the counters, one sysclk behind them.
module timing_gen
    import timing_gen_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int POC_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             sysclk,
    input  logic             poc_n,
    input  logic             run,
    output logic             clk1,
    output logic             clk2,
    output logic             a12,
    output logic             a22,
    output logic             a32,
    output logic             m12,
    output logic             m22,
    output logic             x12,
    output logic             x22,
    output logic             x32,
    output logic             x21_clk2,
    output logic             x31_clk2,
    output logic             sync_n,
    output logic             poc,
    output logic             halted,
    output logic [CNT_W-1:0] mcycle_cnt
);

    localparam logic [0:0] FSM_RUN  = 1'b0;
    localparam logic [0:0] FSM_HALT = 1'b1;

    localparam int POC_W = $clog2(POC_CYCLES + 1);

    logic [0:0]       fsm;
    logic [2:0]       st;
    logic [1:0]       sub;
    logic             tc;
    logic             boundary;
    logic [POC_W-1:0] poc_cnt;
    logic             poc_done;
    strobes_t         strb;

    // In HALT the divider is held cleared so a resume starts at A1/sub0/div0.
    phase_div #(.CLK_DIV(CLK_DIV)) u_phase_div (
        .sysclk (sysclk),
        .poc_n  (poc_n),
        .clr    (fsm == FSM_HALT),
        .sub    (sub),
        .tc     (tc)
    );

    assign boundary = (fsm == FSM_RUN) && tc && (st == ST_X3);
    assign poc_done = (poc_cnt == POC_W'(POC_CYCLES));

    // Counters wrap to A1/0/0 on their own at a boundary, so entering HALT
    // leaves them at 0 without an explicit clear on that edge.
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            fsm        <= FSM_RUN;
            st         <= ST_A1;
            mcycle_cnt <= '0;
            poc_cnt    <= '0;
        end else begin
            case (fsm)
                FSM_RUN: begin
                    if (tc)
                        st <= st + 3'd1;
                    if (boundary) begin
                        mcycle_cnt <= mcycle_cnt + CNT_W'(1);
                        if (!poc_done)
                            poc_cnt <= poc_cnt + POC_W'(1);
                        if (!run)
                            fsm <= FSM_HALT;
                    end
                end
                default: begin
                    st <= ST_A1;
                    if (run)
                        fsm <= FSM_RUN;
                end
            endcase
        end
    end

    // poc only drops while decoding RUN, so a final counted boundary that
    // parks in HALT keeps poc high until the resumed A1 appears.
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            clk1     <= 1'b0;
            clk2     <= 1'b0;
            strb     <= '0;
            x21_clk2 <= 1'b1;
            x31_clk2 <= 1'b1;
            sync_n   <= 1'b1;
            poc      <= 1'b1;
            halted   <= 1'b0;
        end else begin
            halted <= (fsm == FSM_HALT);
            if (fsm == FSM_RUN) begin
                clk1     <= (sub == SP_C1);
                clk2     <= (sub == SP_C2);
                strb     <= state_strobes(st);
                x21_clk2 <= !((st == ST_X2) && (sub == SP_C2));
                x31_clk2 <= !((st == ST_X3) && (sub == SP_C2));
                sync_n   <= (st != ST_X3);
                if (poc_done)
                    poc <= 1'b0;
            end else begin
                clk1     <= 1'b0;
                clk2     <= 1'b0;
                strb     <= '0;
                x21_clk2 <= 1'b1;
                x31_clk2 <= 1'b1;
                sync_n   <= 1'b1;
            end
        end
    end

    assign a12 = strb.a12;
    assign a22 = strb.a22;
    assign a32 = strb.a32;
    assign m12 = strb.m12;
    assign m22 = strb.m22;
    assign x12 = strb.x12;
    assign x22 = strb.x22;
    assign x32 = strb.x32;

endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: scoreboard bench for timing_gen.
// Instance a: CLK_DIV=2, POC_CYCLES=2, CNT_W=16 (run, mid-cycle run pulse,
// halt/resume, mid-X1 reset). Instance b: CLK_DIV=1, POC_CYCLES=1, CNT_W=4
// (sequencing at 32 sysclk per cycle, counter wrap over 17 cycles).
// Output vector bit order: {halted, poc, sync_n, x31_clk2, x21_clk2,
// x32, x22, x12, m22, m12, a32, a22, a12, clk2, clk1}.
module tb_timing_gen;

    typedef struct {
        int          cyc;
        logic [14:0] mask;
        logic [14:0] v;
        bit          chk_cnt;
        int          cnt;
        string       nm;
    } exp_t;

    logic sysclk = 1'b0;
    logic poc_n_a = 1'b0, run_a = 1'b1;
    logic poc_n_b = 1'b0, run_b = 1'b1;

    logic clk1_a, clk2_a, a12_a, a22_a, a32_a, m12_a, m22_a, x12_a, x22_a, x32_a;
    logic x21_a, x31_a, sync_n_a, poc_a, halted_a;
    logic [15:0] cnt_a;
    logic clk1_b, clk2_b, a12_b, a22_b, a32_b, m12_b, m22_b, x12_b, x22_b, x32_b;
    logic x21_b, x31_b, sync_n_b, poc_b, halted_b;
    logic [3:0] cnt_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   stop = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    timing_gen #(.CLK_DIV(2), .POC_CYCLES(2), .CNT_W(16)) u_dut_a (
        .sysclk(sysclk), .poc_n(poc_n_a), .run(run_a),
        .clk1(clk1_a), .clk2(clk2_a),
        .a12(a12_a), .a22(a22_a), .a32(a32_a), .m12(m12_a), .m22(m22_a),
        .x12(x12_a), .x22(x22_a), .x32(x32_a),
        .x21_clk2(x21_a), .x31_clk2(x31_a), .sync_n(sync_n_a),
        .poc(poc_a), .halted(halted_a), .mcycle_cnt(cnt_a)
    );

    timing_gen #(.CLK_DIV(1), .POC_CYCLES(1), .CNT_W(4)) u_dut_b (
        .sysclk(sysclk), .poc_n(poc_n_b), .run(run_b),
        .clk1(clk1_b), .clk2(clk2_b),
        .a12(a12_b), .a22(a22_b), .a32(a32_b), .m12(m12_b), .m22(m22_b),
        .x12(x12_b), .x22(x22_b), .x32(x32_b),
        .x21_clk2(x21_b), .x31_clk2(x31_b), .sync_n(sync_n_b),
        .poc(poc_b), .halted(halted_b), .mcycle_cnt(cnt_b)
    );

    wire [14:0] obs_a = {halted_a, poc_a, sync_n_a, x31_a, x21_a,
                         x32_a, x22_a, x12_a, m22_a, m12_a, a32_a, a22_a, a12_a,
                         clk2_a, clk1_a};
    wire [14:0] obs_b = {halted_b, poc_b, sync_n_b, x31_b, x21_b,
                         x32_b, x22_b, x12_b, m22_b, m12_b, a32_b, a22_b, a12_b,
                         clk2_b, clk1_b};

    initial forever #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: cyc %0d reached time limit, required end of stimulus", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard push helpers ----------------
    task automatic push(input int d, input exp_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Expected outputs while sequencing freely. o is the cycle showing the
    // first A1 output, m0 the counter value at o, pclr the first cycle with
    // poc low, dv the CLK_DIV of the instance.
    task automatic push_run(input int d, input int o, input int from, input int to,
                            input int m0, input int pclr, input int dv, input string nm);
        for (int n = from; n <= to; n++) begin
            exp_t e;
            int p, st, sb;
            p  = (n - o) % (32 * dv);
            st = p / (4 * dv);
            sb = (p / dv) % 4;
            e.v = '0;
            e.v[0]      = (sb == 0);
            e.v[1]      = (sb == 2);
            e.v[2 + st] = 1'b1;
            e.v[10]     = !(st == 6 && sb == 2);
            e.v[11]     = !(st == 7 && sb == 2);
            e.v[12]     = (st != 7);
            e.v[13]     = (n < pclr);
            e.v[14]     = 1'b0;
            e.cyc = n;
            e.mask = '1;
            e.chk_cnt = 1'b1;
            e.cnt = (m0 + (n - o + 1) / (32 * dv)) & ((d == 0) ? 32'hFFFF : 32'hF);
            e.nm = nm;
            push(d, e);
        end
    endtask

    task automatic push_quiet(input int d, input int from, input int to, input int cnt,
                              input logic p, input logic h, input string nm);
        for (int n = from; n <= to; n++) begin
            exp_t e;
            e.cyc = n;
            e.mask = '1;
            e.v = {h, p, 3'b111, 8'h00, 2'b00};
            e.chk_cnt = 1'b1;
            e.cnt = cnt;
            e.nm = nm;
            push(d, e);
        end
    endtask

    task automatic spot(input int d, input int c, input int b, input logic val, input string nm);
        exp_t e;
        e.cyc = c;
        e.mask = 15'd1 << b;
        e.v = 15'(val) << b;
        e.chk_cnt = 1'b0;
        e.cnt = 0;
        e.nm = nm;
        push(d, e);
    endtask

    task automatic spot_cnt(input int d, input int c, input int cnt, input string nm);
        exp_t e;
        e.cyc = c;
        e.mask = '0;
        e.v = '0;
        e.chk_cnt = 1'b1;
        e.cnt = cnt;
        e.nm = nm;
        push(d, e);
    endtask

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge sysclk);
    endtask

    // Called on a negedge; returns on the negedge after the last reset edge.
    task automatic do_reset(input int d, output int t0);
        int c;
        c = cyc;
        if (d == 0) poc_n_a = 1'b0;
        else        poc_n_b = 1'b0;
        push_quiet(d, c + 1, c + 2, 0, 1'b1, 1'b0, "reset");
        @(negedge sysclk);
        @(negedge sysclk);
        t0 = cyc;
        if (d == 0) poc_n_a = 1'b1;
        else        poc_n_b = 1'b1;
    endtask

    task automatic stim_a();
        int t0, o2, t1;
        run_a = 1'b1;
        repeat (2) @(negedge sysclk);
        do_reset(0, t0);
        push_run(0, t0 + 1, t0 + 1, t0 + 256, 0, t0 + 129, 2, "seq_a");
        spot(0, t0 + 1,  0, 1'b1, "clk1_first");
        spot(0, t0 + 2,  0, 1'b1, "clk1_second");
        spot(0, t0 + 3,  0, 1'b0, "clk1_end");
        spot(0, t0 + 5,  1, 1'b1, "clk2_first");
        spot(0, t0 + 6,  1, 1'b1, "clk2_second");
        spot(0, t0 + 7,  1, 1'b0, "clk2_end");
        spot(0, t0 + 8,  2, 1'b1, "a12_last");
        spot(0, t0 + 9,  3, 1'b1, "a22_start");
        spot(0, t0 + 53, 10, 1'b0, "x21_low");
        spot(0, t0 + 55, 10, 1'b1, "x21_high");
        spot(0, t0 + 61, 11, 1'b0, "x31_low");
        spot(0, t0 + 57, 12, 1'b0, "sync_low");
        spot(0, t0 + 56, 12, 1'b1, "sync_high");
        spot(0, t0 + 65, 2, 1'b1, "a1_second");
        spot(0, t0 + 128, 13, 1'b1, "poc_held");
        spot(0, t0 + 129, 13, 1'b0, "poc_fall");
        spot(0, t0 + 129, 2, 1'b1, "a1_third");
        spot_cnt(0, t0 + 63, 0, "cnt_before");
        spot_cnt(0, t0 + 64, 1, "cnt_first");
        spot_cnt(0, t0 + 129, 2, "cnt_at_poc");
        // mid-cycle run pulse must be ignored
        wait_cyc(t0 + 99);
        run_a = 1'b0;
        wait_cyc(t0 + 101);
        run_a = 1'b1;
        // drop run during M1 of the fourth cycle
        wait_cyc(t0 + 219);
        run_a = 1'b0;
        push_quiet(0, t0 + 257, t0 + 277, 4, 1'b0, 1'b1, "halt_a");
        wait_cyc(t0 + 276);
        run_a = 1'b1;
        o2 = t0 + 278;
        push_run(0, o2, o2, o2 + 42, 4, 0, 2, "resume_a");
        spot(0, o2, 0, 1'b1, "resume_clk1");
        spot(0, o2, 2, 1'b1, "resume_a12");
        spot(0, o2, 14, 1'b0, "resume_halted");
        // reset in the middle of X1
        wait_cyc(o2 + 42);
        do_reset(0, t1);
        push_run(0, t1 + 1, t1 + 1, t1 + 140, 0, t1 + 129, 2, "restart_a");
        spot(0, t1 + 128, 13, 1'b1, "repoc_held");
        spot(0, t1 + 129, 13, 1'b0, "repoc_fall");
        wait_cyc(t1 + 142);
    endtask

    task automatic stim_b();
        int t0;
        run_b = 1'b1;
        repeat (2) @(negedge sysclk);
        do_reset(1, t0);
        push_run(1, t0 + 1, t0 + 1, t0 + 552, 0, t0 + 33, 1, "seq_b");
        spot(1, t0 + 1, 0, 1'b1, "b_clk1");
        spot(1, t0 + 2, 0, 1'b0, "b_clk1_end");
        spot(1, t0 + 3, 1, 1'b1, "b_clk2");
        spot(1, t0 + 4, 2, 1'b1, "b_a12_last");
        spot(1, t0 + 5, 3, 1'b1, "b_a22_start");
        spot(1, t0 + 32, 13, 1'b1, "b_poc_held");
        spot(1, t0 + 33, 13, 1'b0, "b_poc_fall");
        spot(1, t0 + 33, 2, 1'b1, "b_a1_second");
        spot_cnt(1, t0 + 511, 15, "b_cnt_15");
        spot_cnt(1, t0 + 512, 0, "b_cnt_wrap");
        spot_cnt(1, t0 + 544, 1, "b_cnt_1");
        wait_cyc(t0 + 554);
    endtask

    // ---------------- monitor ----------------
    task automatic check_item(input int d, input exp_t e, input logic [14:0] obs, input int cnt);
        bit bad;
        n_tests++;
        bad = ((obs & e.mask) != (e.v & e.mask)) || (e.chk_cnt && (cnt != e.cnt));
        if (bad) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %b cnt %0d, required %b cnt %0d (mask %b)",
                     e.nm, d, e.cyc, obs & e.mask, cnt, e.v & e.mask, e.cnt, e.mask);
        end
    endtask

    task automatic check_inv(input int d, input logic [14:0] obs);
        n_tests++;
        if (obs[0] && obs[1]) begin
            n_fail++;
            $display("FAIL clk_overlap dut%0d cyc %0d: got clk1=1 clk2=1, required not both", d, cyc);
        end
        if (|obs[9:2] && !obs[14]) begin
            n_tests++;
            if (obs[12] != !obs[9]) begin
                n_fail++;
                $display("FAIL sync_vs_x32 dut%0d cyc %0d: got sync_n=%b x32=%b, required sync_n==~x32",
                         d, cyc, obs[12], obs[9]);
            end
        end
    endtask

    task automatic monitor_step();
        int i;
        i = 0;
        while (i < qa.size()) begin
            if (qa[i].cyc == cyc) begin
                check_item(0, qa[i], obs_a, int'(cnt_a));
                qa.delete(i);
            end else if (qa[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_a %s: cyc %0d, required check at %0d", qa[i].nm, cyc, qa[i].cyc);
                qa.delete(i);
            end else begin
                i++;
            end
        end
        i = 0;
        while (i < qb.size()) begin
            if (qb[i].cyc == cyc) begin
                check_item(1, qb[i], obs_b, int'(cnt_b));
                qb.delete(i);
            end else if (qb[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_b %s: cyc %0d, required check at %0d", qb[i].nm, cyc, qb[i].cyc);
                qb.delete(i);
            end else begin
                i++;
            end
        end
        check_inv(0, obs_a);
        check_inv(1, obs_b);
    endtask

    initial begin
        fork
            begin
                fork
                    stim_a();
                    stim_b();
                join
                repeat (3) @(negedge sysclk);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge sysclk);
                    #2;
                    monitor_step();
                end
            end
        join
        n_tests++;
        if (qa.size() + qb.size() != 0) begin
            n_fail++;
            $display("FAIL pending: got %0d unchecked expectations, required 0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
